// File: rtl/sevensegment_capture_if.sv
// Seven-segment capture bus: scanned display lines in, decoded digits out.
// master = scanner/consumer side, slave = capture block.
interface sevensegment_capture_if #(
  parameter int DIGITS = 4
);
  logic [DIGITS-1:0]   digit_en;
  logic [7:0]          segments;
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   valid;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   bad_pattern;
  logic                update;
  logic [2:0]          update_digit;

  modport master (
    output digit_en, segments,
    input  value, valid, dp, bad_pattern,
    input  update, update_digit
  );

  modport slave (
    input  digit_en, segments,
    output value, valid, dp, bad_pattern,
    output update, update_digit
  );
endinterface

// File: rtl/sevensegment_capture.sv
// Captures a scanned 7-seg bus; a pattern stable for STABLE_CYCLES samples
// is decoded to hex. Ports: clk, rst_n, bus (slave modport, see _if).
module sevensegment_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  sevensegment_capture_if.slave bus
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    CAPTURED
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DIGITS-1:0] r_en, ref_en;
  logic [7:0] r_seg, ref_seg;
  logic load;
  logic same;
  logic one_hot;
  logic capture;
  logic hit;
  logic [3:0] dig;
  logic [2:0] idx;

  logic [4*DIGITS-1:0] value_q;
  logic [DIGITS-1:0] valid_q;
  logic [DIGITS-1:0] dp_q;
  logic [DIGITS-1:0] bad_q;
  logic update_q;
  logic [2:0] update_digit_q;

  assign same = (r_en == ref_en) && (r_seg == ref_seg);
  assign one_hot = (r_en != '0) &&
                   ((r_en & (r_en - DIGITS'(1))) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en    <= '0;
      r_seg   <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      ref_en  <= '0;
      ref_seg <= '0;
    end else begin
      r_en    <= bus.digit_en;
      r_seg   <= bus.segments;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        ref_en  <= r_en;
        ref_seg <= r_seg;
      end
    end
  end

  // IDLE and "CAPTURED with a change" behave identically.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (one_hot) begin
          state_d = TRACK;
          cnt_d   = CW'(1);
          load    = 1'b1;
        end else begin
          cnt_d = '0;
        end
      end
      TRACK: begin
        if (same) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) state_d = CAPTURED;
        end else if (one_hot) begin
          cnt_d = CW'(1);
          load  = 1'b1;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      CAPTURED: begin
        if (!same) begin
          if (one_hot) begin
            state_d = TRACK;
            cnt_d   = CW'(1);
            load    = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    capture = (state_q == TRACK) && same && (cnt_q == CNT_LAST);
    idx = '0;
    for (int i = 0; i < DIGITS; i++)
      if (ref_en[i]) idx = 3'(i);
    hit = 1'b1;
    dig = '0;
    case (ref_seg[6:0])
      7'h3F: dig = 4'h0;
      7'h06: dig = 4'h1;
      7'h5B: dig = 4'h2;
      7'h4F: dig = 4'h3;
      7'h66: dig = 4'h4;
      7'h6D: dig = 4'h5;
      7'h7D: dig = 4'h6;
      7'h07: dig = 4'h7;
      7'h7F: dig = 4'h8;
      7'h6F: dig = 4'h9;
      7'h77: dig = 4'hA;
      7'h7C: dig = 4'hB;
      7'h39: dig = 4'hC;
      7'h5E: dig = 4'hD;
      7'h79: dig = 4'hE;
      7'h71: dig = 4'hF;
      default: hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q        <= '0;
      valid_q        <= '0;
      dp_q           <= '0;
      bad_q          <= '0;
      update_q       <= 1'b0;
      update_digit_q <= '0;
    end else begin
      update_q <= capture;
      if (capture) begin
        update_digit_q <= idx;
        for (int i = 0; i < DIGITS; i++) begin
          if (3'(i) == idx) begin
            dp_q[i] <= ref_seg[7];
            if (hit) begin
              value_q[4*i +: 4] <= dig;
              valid_q[i]        <= 1'b1;
              bad_q[i]          <= 1'b0;
            end else begin
              bad_q[i] <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign bus.value        = value_q;
  assign bus.valid        = valid_q;
  assign bus.dp           = dp_q;
  assign bus.bad_pattern  = bad_q;
  assign bus.update       = update_q;
  assign bus.update_digit = update_digit_q;

endmodule

// File: tb/tb_sevensegment_capture.sv
// Randomised bench for sevensegment_capture against a run-length model.
// Directed phases pin the model with literal expectations.
module tb_sevensegment_capture;

  localparam int D = 4;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sevensegment_capture_if #(.DIGITS(D)) ifc ();

  sevensegment_capture #(
    .DIGITS(D),
    .STABLE_CYCLES(S)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(ifc)
  );

  always #5 clk = ~clk;

  bit [6:0] lut [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int passed = 0;
  int total = 0;

  bit [15:0] m_value;
  bit [3:0]  m_valid, m_dp, m_bad;
  bit        m_upd;
  int        m_dig;
  bit [3:0]  prev_en;
  bit [7:0]  prev_seg;
  bit        prev_ok;
  int        run;
  bit        pend;
  int        pend_dig;
  bit [7:0]  pend_seg;

  int edge_no;
  int first_upd;
  int upd_cnt;
  int last_dig;
  int digs[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    else
      passed++;
  endtask

  function automatic int lut_find(input bit [6:0] s);
    for (int k = 0; k < 16; k++)
      if (lut[k] == s) return k;
    return -1;
  endfunction

  task automatic model_clear();
    m_value = '0; m_valid = '0; m_dp = '0; m_bad = '0;
    m_upd = 0; m_dig = 0;
    prev_ok = 0; run = 0; pend = 0;
  endtask

  task automatic compare();
    chk("value", 32'(ifc.value), 32'(m_value));
    chk("valid", 32'(ifc.valid), 32'(m_valid));
    chk("dp", 32'(ifc.dp), 32'(m_dp));
    chk("bad_pattern", 32'(ifc.bad_pattern), 32'(m_bad));
    chk("update", 32'(ifc.update), 32'(m_upd));
    if (m_upd) chk("update_digit", 32'(ifc.update_digit), 32'(m_dig));
  endtask

  // Drive one sample; a pair seen S times in a row (one-hot) is captured
  // at the following edge.
  task automatic step(input bit [3:0] en, input bit [7:0] seg);
    int k;
    ifc.digit_en = en;
    ifc.segments = seg;
    m_upd = pend;
    if (pend) begin
      m_dig = pend_dig;
      m_dp[pend_dig] = pend_seg[7];
      k = lut_find(pend_seg[6:0]);
      if (k >= 0) begin
        m_value[4*pend_dig +: 4] = 4'(k);
        m_valid[pend_dig] = 1;
        m_bad[pend_dig] = 0;
      end else begin
        m_bad[pend_dig] = 1;
      end
    end
    if (prev_ok && en == prev_en && seg == prev_seg) run++;
    else run = 1;
    prev_ok = 1; prev_en = en; prev_seg = seg;
    pend = ($countones(en) == 1) && (run == S);
    pend_dig = $clog2(en);
    pend_seg = seg;
    @(posedge clk);
    edge_no++;
    @(negedge clk);
    compare();
    if (ifc.update) begin
      upd_cnt++;
      last_dig = int'(ifc.update_digit);
      digs.push_back(last_dig);
      if (first_upd < 0) first_upd = edge_no;
    end
  endtask

  task automatic hold(input bit [3:0] en, input bit [7:0] seg, input int n);
    for (int i = 0; i < n; i++) step(en, seg);
  endtask

  task automatic clr_stats();
    edge_no = 0; first_upd = -1; upd_cnt = 0; digs.delete();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_value", 32'(ifc.value), 32'h0);
    chk("rst_valid", 32'(ifc.valid), 32'h0);
    chk("rst_dp", 32'(ifc.dp), 32'h0);
    chk("rst_bad", 32'(ifc.bad_pattern), 32'h0);
    chk("rst_update", 32'(ifc.update), 32'h0);
    chk("rst_update_digit", 32'(ifc.update_digit), 32'h0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    clr_stats();
  endtask

  initial begin
    bit [3:0] en;
    bit [7:0] seg;
    ifc.digit_en = '0;
    ifc.segments = '0;
    model_clear();
    clr_stats();
    repeat (2) @(negedge clk);
    do_reset();

    // single capture, latency STABLE_CYCLES+1
    hold(4'b0001, 8'h3F, 6);
    chk("t1_first_update_edge", 32'(first_upd), 32'd5);
    chk("t1_update_count", 32'(upd_cnt), 32'd1);
    chk("t1_value0", 32'(ifc.value[3:0]), 32'h0);
    chk("t1_valid", 32'(ifc.valid), 32'b0001);

    // two digits back to back
    hold(4'b0000, 8'h00, 2);
    clr_stats();
    hold(4'b0100, 8'h7C, 4);
    hold(4'b0001, 8'h86, 4);
    hold(4'b0000, 8'h00, 2);
    chk("t2_value2", 32'(ifc.value[11:8]), 32'hB);
    chk("t2_value0", 32'(ifc.value[3:0]), 32'h1);
    chk("t2_dp0", 32'(ifc.dp[0]), 32'd1);
    chk("t2_update_count", 32'(upd_cnt), 32'd2);
    if (digs.size() == 2) begin
      chk("t2_digit_a", 32'(digs[0]), 32'd2);
      chk("t2_digit_b", 32'(digs[1]), 32'd0);
    end

    // bad pattern leaves value/valid alone
    hold(4'b0010, 8'h6D, 5);
    hold(4'b0010, 8'h49, 4);
    hold(4'b0000, 8'h00, 2);
    chk("t3_bad1", 32'(ifc.bad_pattern[1]), 32'd1);
    chk("t3_value1", 32'(ifc.value[7:4]), 32'h5);
    chk("t3_valid1", 32'(ifc.valid[1]), 32'd1);
    chk("t3_last_digit", 32'(last_dig), 32'd1);

    // glitches
    clr_stats();
    for (int i = 0; i < 20; i++)
      step(4'b1000, ((i / 3) % 2 == 0) ? 8'h06 : 8'h5B);
    hold(4'b0011, 8'h3F, 8);
    hold(4'b0000, 8'h00, 2);
    chk("t4_no_update", 32'(upd_cnt), 32'd0);

    // reset mid-dwell
    for (int d = 0; d < D; d++) hold(4'(1 << d), {1'b0, lut[d + 7]}, 5);
    hold(4'b0100, 8'h66, 2);
    do_reset();
    hold(4'b0100, 8'h4F, 6);
    chk("t5_first_update_edge", 32'(first_upd), 32'd5);
    chk("t5_value2", 32'(ifc.value[11:8]), 32'h3);
    chk("t5_valid", 32'(ifc.valid), 32'b0100);

    // every code on every digit
    for (int d = 0; d < D; d++)
      for (int c = 0; c < 16; c++)
        hold(4'(1 << d), {1'($urandom_range(0, 1)), lut[c]}, S + 1);
    hold(4'b0000, 8'h00, 2);
    chk("t6_value", 32'(ifc.value), 32'hFFFF);
    chk("t6_bad", 32'(ifc.bad_pattern), 32'h0);
    chk("t6_valid", 32'(ifc.valid), 32'hF);

    // random dwells
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) < 80) en = 4'(1 << $urandom_range(0, 3));
      else en = 4'($urandom);
      if ($urandom_range(0, 99) < 70)
        seg = {1'($urandom_range(0, 1)), lut[$urandom_range(0, 15)]};
      else seg = 8'($urandom);
      hold(en, seg, $urandom_range(1, S + 2));
      if ($urandom_range(0, 99) < 2) do_reset();
    end
    hold(4'b0000, 8'h00, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sevensegment_capture.md
# sevensegment_capture

Captures a multiplexed seven-segment display bus and converts it back to hex digits. It watches the scanned digit enables and segment lines, accepts a pattern only after it has been stable for a programmable number of samples, and decodes the accepted pattern to a 4-bit value per digit. Typical uses are self-checking display logic on the board and reading back the lit display state over the debug path.

## Interface
Parameters:
- DIGITS, 4: number of scanned digit positions (1–8).
- STABLE_CYCLES, 4: number of consecutive identical samples required before capture (2–255).

Ports:
- clk, input, 1: single clock. All logic is rising-edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- digit_en, input, DIGITS: digit-select lines from the scanner, active-high. Exactly one bit set means a valid select.
- segments, input, 8: segment bus. bit7 = dp, bits 6:0 = g,f,e,d,c,b,a. Segment bit 1 = lit.
- value, output, 4*DIGITS: decoded hex per digit. Digit i is at value[4i+3:4i].
- valid, output, DIGITS: digit i holds a successfully decoded pattern.
- dp, output, DIGITS: captured decimal point per digit.
- bad_pattern, output, DIGITS: the last capture on digit i did not match the code table.
- update, output, 1: one-cycle pulse on every capture, valid or bad.
- update_digit, output, 3: index of the digit captured. Meaningful while update = 1.

## Operation
- Input stage: digit_en and segments are registered every clock into r_en and r_seg.
- Control state machine, with a saturating counter cnt of width ceil(log2(STABLE_CYCLES+1)):
  - IDLE:
    - If r_en is not one-hot (zero or multiple bits set), stay in IDLE with cnt = 0.
    - If r_en is one-hot, go to TRACK with cnt = 1. Latch the reference pair {ref_en, ref_seg} = {r_en, r_seg}.
  - TRACK:
    - If {r_en, r_seg} == ref, increment cnt.
    - If the pair differs and r_en is one-hot, re-latch ref and set cnt = 1.
    - If r_en is not one-hot, go to IDLE.
    - When the incremented cnt reaches STABLE_CYCLES, capture and go to CAPTURED.
  - CAPTURED:
    - Stay while {r_en, r_seg} == ref. There is exactly one capture per dwell.
    - On any change, act exactly as IDLE does on that sample.
- Capture for digit i = index of the set bit in ref_en:
  - dp[i] = ref_seg[7].
  - Decode ref_seg[6:0]: 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x6F→9, 0x77→A, 0x7C→B, 0x39→C, 0x5E→D, 0x79→E, 0x71→F.
  - On a table match: write value[i], set valid[i] = 1, clear bad_pattern[i].
  - On no match: value[i] and valid[i] are unchanged, and bad_pattern[i] = 1.
  - update = 1 for one cycle and update_digit = i.
- Other digits are never modified by a capture.

## Timing
- Reset (asynchronous, immediate):
  - value = 0, valid = 0, dp = 0, bad_pattern = 0.
  - update = 0, update_digit = 0.
  - State = IDLE, cnt = 0, r_en = 0, r_seg = 0, ref = 0.
- Latency: inputs held constant from cycle 0 (first sampled at edge 1) update outputs at edge STABLE_CYCLES+1. The update pulse is high for the cycle that follows that edge.
- A pair held for fewer than STABLE_CYCLES consecutive samples produces no capture and no output change.
- A held pair produces one update only, however long it is held. A new capture on the same digit requires a change followed by stability again.
- Back-to-back digits: a scan dwell of STABLE_CYCLES+1 cycles per digit captures every digit. Updates are at least STABLE_CYCLES cycles apart.
- If a change arrives on the same sample where cnt would reach STABLE_CYCLES, the change wins and there is no capture.
- If reset asserts mid-dwell, all state is cleared. After release, counting restarts from the next valid sample.
- All outputs are registered. There is no combinational path from input to output.

## Test plan
- Reset release, then digit_en = 0001 and segments = 0x3F held for 6 cycles:
  - update pulses once at edge 5.
  - value[3:0] = 0 and valid = 0001.
  - Nothing else changes.
- digit_en = 0100, segments = 0x7C held for 4 samples, then digit_en = 0001, segments = 0x86 held for 4 samples:
  - value[11:8] = B.
  - value[3:0] = 1 and dp[0] = 1.
  - Two update pulses, with update_digit = 2 and then 0.
- digit_en = 0010, segments = 0x49 held for 4 samples, after digit 1 already holds 5:
  - bad_pattern[1] = 1.
  - value[7:4] = 5 and valid[1] = 1 (both unchanged).
  - update pulses with update_digit = 1.
- Glitches:
  - digit_en = 1000 with segments toggling 0x06/0x5B every 3 cycles for 20 cycles: no update, outputs unchanged.
  - digit_en = 0011 with a stable 0x3F: no update.
- Reset mid-operation: capture 4 digits, then pulse rst_n low for 1 cycle during a dwell:
  - All outputs are 0 at the asynchronous edge.
  - The next stable dwell captures normally with the same latency.
- Sweep all 16 table codes on each digit:
  - value equals the table entry.
  - bad_pattern stays 0.
